// File: rtl/vga_frame_grabber_pkg.sv
// Shared definitions for the VGA frame grabber: FSM states, window geometry
// and period/position counter sizing.
package vga_frame_grabber_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE
  } state_t;

  localparam int unsigned WIN_SIZE    = 256;
  localparam int unsigned DEF_H_START = 240;
  localparam int unsigned DEF_V_START = 141;

  localparam int unsigned             PERIOD_W   = 11;
  localparam logic [PERIOD_W-1:0]     PERIOD_MAX = '1;

  localparam int unsigned             POS_W   = 10;
  localparam logic [POS_W-1:0]        POS_MAX = '1;

endpackage

// File: rtl/vga_frame_grabber_line_period_meter.sv
// Measures cycles between Hsync rises and qualifies lock once LOCK_LINES
// consecutive periods have the same length.
module vga_line_period_meter
  import vga_frame_grabber_pkg::*;
#(
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic                slow_clock,
  input  logic                Reset,
  input  logic                hsync_rise,
  output logic [PERIOD_W-1:0] oLinePeriod,
  output logic                oLocked
);

  localparam int unsigned RUN_W = $clog2(LOCK_LINES + 1);

  logic [PERIOD_W-1:0] count;
  logic [RUN_W-1:0]    run;
  logic [RUN_W-1:0]    run_next;
  logic                seen_edge;

  // The interval ending at the first rise after reset (or after a timeout)
  // is not a real line, so it never counts toward the run.
  always_comb begin
    run_next = run;
    if (!seen_edge) begin
      run_next = '0;
    end else if (count == oLinePeriod) begin
      if (run < RUN_W'(LOCK_LINES)) run_next = run + RUN_W'(1);
    end else begin
      run_next = RUN_W'(1);
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!Reset) begin
      count       <= '0;
      run         <= '0;
      seen_edge   <= 1'b0;
      oLinePeriod <= '0;
      oLocked     <= 1'b0;
    end else if (hsync_rise) begin
      count       <= PERIOD_W'(1);
      oLinePeriod <= count;
      seen_edge   <= 1'b1;
      run         <= run_next;
      oLocked     <= (run_next >= RUN_W'(LOCK_LINES));
    end else if (count == PERIOD_MAX) begin
      run       <= '0;
      seen_edge <= 1'b0;
      oLocked   <= 1'b0;
    end else begin
      count <= count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/vga_frame_grabber.sv
// Recovers pixel/line position from a VGA stream and captures one 256x256
// window of a frame into an external pixel memory on request.
module vga_frame_grabber
  import vga_frame_grabber_pkg::*;
#(
  parameter int unsigned H_START    = DEF_H_START,
  parameter int unsigned V_START    = DEF_V_START,
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic                slow_clock,
  input  logic                Reset,
  input  logic [2:0]          iVGA_RGB,
  input  logic                iHsync,
  input  logic                iVsync,
  input  logic                iCaptureRequest,
  output logic                oWriteEnable,
  output logic [15:0]         oWriteAddress,
  output logic [2:0]          oWriteData,
  output logic                oLocked,
  output logic [PERIOD_W-1:0] oLinePeriod,
  output logic                oBusy,
  output logic                oDone,
  output logic                oError
);

  localparam logic [POS_W-1:0] X_LO = POS_W'(H_START);
  localparam logic [POS_W-1:0] X_HI = POS_W'(H_START + WIN_SIZE - 1);
  localparam logic [POS_W-1:0] Y_LO = POS_W'(V_START);
  localparam logic [POS_W-1:0] Y_HI = POS_W'(V_START + WIN_SIZE - 1);

  state_t           state;
  logic [2:0]       rgb_s1;
  logic             hs_s1, hs_s2, vs_s1, vs_s2;
  logic             hs_rise, vs_rise, frame_start;
  logic             frame_pending;
  logic [POS_W-1:0] x_q, y_q, x_cur, y_cur;
  logic             in_win, wr, last_write;
  logic [15:0]      waddr;

  always_ff @(posedge slow_clock) begin
    if (!Reset) begin
      rgb_s1 <= '0;
      hs_s1  <= 1'b0;
      hs_s2  <= 1'b0;
      vs_s1  <= 1'b0;
      vs_s2  <= 1'b0;
    end else begin
      rgb_s1 <= iVGA_RGB;
      hs_s1  <= iHsync;
      hs_s2  <= hs_s1;
      vs_s1  <= iVsync;
      vs_s2  <= vs_s1;
    end
  end

  assign hs_rise     = hs_s1 & ~hs_s2;
  assign vs_rise     = vs_s1 & ~vs_s2;
  assign frame_start = hs_rise & (frame_pending | vs_rise);

  // x_cur/y_cur are the position of the sample currently held in s1.
  always_comb begin
    x_cur = (x_q == POS_MAX) ? x_q : x_q + POS_W'(1);
    y_cur = y_q;
    if (hs_rise) begin
      x_cur = '0;
      if (frame_start)       y_cur = '0;
      else if (y_q != POS_MAX) y_cur = y_q + POS_W'(1);
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!Reset) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_pending <= 1'b0;
    end else begin
      x_q <= x_cur;
      y_q <= y_cur;
      if (frame_start)  frame_pending <= 1'b0;
      else if (vs_rise) frame_pending <= 1'b1;
    end
  end

  vga_line_period_meter #(
    .LOCK_LINES(LOCK_LINES)
  ) u_meter (
    .slow_clock (slow_clock),
    .Reset      (Reset),
    .hsync_rise (hs_rise),
    .oLinePeriod(oLinePeriod),
    .oLocked    (oLocked)
  );

  assign in_win = (x_cur >= X_LO) && (x_cur <= X_HI) &&
                  (y_cur >= Y_LO) && (y_cur <= Y_HI);
  assign waddr  = {8'(y_cur - Y_LO), 8'(x_cur - X_LO)};

  // The line that starts the capture is y=0, so writes are allowed on the
  // ARM->CAPTURE transition cycle as well as in CAPTURE.
  assign wr = in_win && oLocked &&
              ((state == CAPTURE && !last_write) || (state == ARM && frame_start));

  always_ff @(posedge slow_clock) begin
    if (!Reset) begin
      state         <= IDLE;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
      oError        <= 1'b0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oWriteData    <= '0;
      last_write    <= 1'b0;
    end else begin
      oDone        <= 1'b0;
      oError       <= 1'b0;
      oWriteEnable <= wr;
      if (wr) begin
        oWriteAddress <= waddr;
        oWriteData    <= rgb_s1;
        if (waddr == '1) last_write <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (iCaptureRequest && oLocked) begin
            state <= ARM;
            oBusy <= 1'b1;
          end
        end
        ARM: begin
          if (!oLocked) begin
            state  <= IDLE;
            oBusy  <= 1'b0;
            oError <= 1'b1;
          end else if (frame_start) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (last_write) begin
            state      <= IDLE;
            oBusy      <= 1'b0;
            oDone      <= 1'b1;
            last_write <= 1'b0;
          end else if (!oLocked) begin
            state  <= IDLE;
            oBusy  <= 1'b0;
            oError <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_grabber.sv
// Scoreboard bench: a line/frame generator pushes the expected window writes,
// a monitor pops and compares them against the DUT write port.
module tb_vga_frame_grabber;

  localparam int H_START    = 2;
  localparam int V_START    = 2;
  localparam int LOCK_LINES = 4;
  localparam int LINE       = 260;
  localparam int SYNC       = 4;
  localparam int WIN        = 256;

  logic        slow_clock = 1'b0;
  logic        Reset;
  logic [2:0]  iVGA_RGB;
  logic        iHsync, iVsync, iCaptureRequest;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [2:0]  oWriteData;
  logic        oLocked;
  logic [10:0] oLinePeriod;
  logic        oBusy, oDone, oError;

  always #5 slow_clock = ~slow_clock;

  vga_frame_grabber #(
    .H_START   (H_START),
    .V_START   (V_START),
    .LOCK_LINES(LOCK_LINES)
  ) dut (
    .slow_clock     (slow_clock),
    .Reset          (Reset),
    .iVGA_RGB       (iVGA_RGB),
    .iHsync         (iHsync),
    .iVsync         (iVsync),
    .iCaptureRequest(iCaptureRequest),
    .oWriteEnable   (oWriteEnable),
    .oWriteAddress  (oWriteAddress),
    .oWriteData     (oWriteData),
    .oLocked        (oLocked),
    .oLinePeriod    (oLinePeriod),
    .oBusy          (oBusy),
    .oDone          (oDone),
    .oError         (oError)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [18:0] exp_q[$];
  bit          model_capture = 1'b0;
  int          model_y = 0;
  int          pushed = 0;
  int          n_writes = 0;
  int          n_done = 0;
  int          n_error = 0;
  bit          prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},     32'(oWriteEnable),  0);
    check({tag, "_addr"},   32'(oWriteAddress), 0);
    check({tag, "_data"},   32'(oWriteData),    0);
    check({tag, "_locked"}, 32'(oLocked),       0);
    check({tag, "_period"}, 32'(oLinePeriod),   0);
    check({tag, "_busy"},   32'(oBusy),         0);
    check({tag, "_done"},   32'(oDone),         0);
    check({tag, "_error"},  32'(oError),        0);
  endtask

  // One line: hsync high from x=0 (its rise marks x=0), low for the last SYNC
  // samples. vs_line drops Vsync and raises it 3 samples before the next line.
  task automatic send_line(input int len, input bit vs_line, input int req_x, input int rst_x);
    logic [2:0] rgb;
    for (int x = 0; x < len; x++) begin
      @(negedge slow_clock);
      rgb             = 3'($urandom_range(0, 7));
      iVGA_RGB        = rgb;
      iHsync          = (x < len - SYNC);
      iVsync          = !(vs_line && x >= len - SYNC - 8 && x < len - 3);
      iCaptureRequest = (x == req_x);
      Reset           = (x != rst_x);
      if (model_capture && pushed < WIN * WIN &&
          model_y >= V_START && model_y < V_START + WIN &&
          x >= H_START && x < H_START + WIN) begin
        exp_q.push_back({16'((model_y - V_START) * WIN + (x - H_START)), rgb});
        pushed++;
      end
    end
    if (model_capture) model_y++;
  endtask

  initial begin : monitor
    logic [18:0] e;
    forever begin
      @(negedge slow_clock);
      if (oWriteEnable) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got write addr 0x%0h data %0d, required no write",
                   oWriteAddress, oWriteData);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(oWriteAddress), 32'(e[18:3]));
          check("write_data", 32'(oWriteData),    32'(e[2:0]));
        end
      end
      if (oDone) begin
        n_done++;
        check("done_after_last_write", 32'(prev_last), 1);
        check("busy_low_at_done", 32'(oBusy), 0);
      end
      if (oError) begin
        n_error++;
        check("busy_low_at_error", 32'(oBusy), 0);
      end
      prev_last = oWriteEnable && (oWriteAddress == 16'hFFFF);
    end
  end

  initial begin : stimulus
    int writes_before;
    Reset = 1'b0; iHsync = 1'b0; iVsync = 1'b0; iVGA_RGB = '0; iCaptureRequest = 1'b0;
    repeat (2) @(negedge slow_clock);
    check_all_zero("reset");

    // Lock acquisition; a request while unlocked must be ignored.
    send_line(LINE, 1'b0, -1, -1);
    send_line(LINE, 1'b0, 10, -1);
    check("busy_unlocked_request", 32'(oBusy), 0);
    send_line(LINE, 1'b0, -1, -1);
    send_line(LINE, 1'b0, -1, -1);
    check("locked_before_5th_rise", 32'(oLocked), 0);
    check("busy_before_lock", 32'(oBusy), 0);
    send_line(LINE, 1'b0, -1, -1);
    check("locked_after_5th_rise", 32'(oLocked), 1);
    check("line_period", 32'(oLinePeriod), LINE);
    check("done_idle", 32'(oDone), 0);
    check("error_idle", 32'(oError), 0);

    // Full capture with a second request mid-capture.
    send_line(LINE, 1'b1, int'($urandom_range(0, LINE - 20)), -1);
    check("busy_armed", 32'(oBusy), 1);
    model_capture = 1'b1; model_y = 0; pushed = 0;
    for (int l = 0; l < V_START + WIN; l++)
      send_line(LINE, 1'b0, (l == 40) ? 17 : -1, -1);
    model_capture = 1'b0;
    send_line(LINE, 1'b0, -1, -1);
    check("capture_write_count", 32'(n_writes), WIN * WIN);
    check("capture_done_count", 32'(n_done), 1);
    check("capture_error_count", 32'(n_error), 0);
    check("capture_queue_drained", 32'(exp_q.size()), 0);
    check("capture_busy_after", 32'(oBusy), 0);

    // Abort: one short line during capture.
    writes_before = n_writes;
    send_line(LINE, 1'b1, 5, -1);
    model_capture = 1'b1; model_y = 0; pushed = 0;
    for (int l = 0; l < V_START + 4; l++) send_line(LINE, 1'b0, -1, -1);
    send_line(LINE - 1, 1'b0, -1, -1);
    model_capture = 1'b0;
    send_line(LINE, 1'b0, -1, -1);
    send_line(LINE, 1'b0, -1, -1);
    check("abort_error_count", 32'(n_error), 1);
    check("abort_done_count", 32'(n_done), 1);
    check("abort_write_count", 32'(n_writes - writes_before), 32'(pushed));
    check("abort_partial", 32'(pushed < WIN * WIN), 1);
    check("abort_locked", 32'(oLocked), 0);
    check("abort_busy", 32'(oBusy), 0);
    check("abort_queue_drained", 32'(exp_q.size()), 0);

    // Relock, then reset mid-capture.
    repeat (4) send_line(LINE, 1'b0, -1, -1);
    check("relocked", 32'(oLocked), 1);
    send_line(LINE, 1'b1, 3, -1);
    model_capture = 1'b1; model_y = 0; pushed = 0;
    for (int l = 0; l < V_START + 2; l++) send_line(LINE, 1'b0, -1, -1);
    send_line(LINE, 1'b0, -1, LINE - 1);
    model_capture = 1'b0;
    @(negedge slow_clock);
    check_all_zero("midreset");
    Reset = 1'b1;
    repeat (3) send_line(LINE, 1'b0, -1, -1);
    check("reset_queue_drained", 32'(exp_q.size()), 0);
    check("reset_done_count", 32'(n_done), 1);
    check("reset_error_count", 32'(n_error), 1);
    check("reset_busy", 32'(oBusy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_frame_grabber.md
# vga_frame_grabber

Receive-side counterpart of the VGA timing generator. It takes the RGB/Hsync/Vsync stream produced in the `slow_clock` domain and recovers pixel/line position from the sync edges. It also qualifies lock on the line period and, on request, captures one 256×256 window of a frame into an external 64 K×3 pixel memory through a write port. It is used for loop-back self-test and for frame readback.

## Interface
- `H_START`, 240: first captured pixel column (recovered x).
- `V_START`, 141: first captured line (recovered y).
- `LOCK_LINES`, 4: consecutive equal line periods required for lock.
- `slow_clock` in 1: sole clock, rising edge.
- `Reset` in 1: synchronous, active-low reset.
- `iVGA_RGB` in 3: pixel colour {R,G,B}.
- `iHsync` in 1: high during the active+porch part of the line, low during the sync pulse.
- `iVsync` in 1: same polarity convention as `iHsync`, per frame.
- `iCaptureRequest` in 1: one-cycle pulse; start a capture.
- `oWriteEnable` out 1: pixel memory write strobe.
- `oWriteAddress` out 16: {row[7:0], col[7:0]} within the window.
- `oWriteData` out 3: captured colour.
- `oLocked` out 1: line timing qualified.
- `oLinePeriod` out 11: last measured line period in cycles.
- `oBusy` out 1: capture armed or in progress.
- `oDone` out 1: one-cycle pulse, capture completed.
- `oError` out 1: one-cycle pulse, capture aborted by loss of lock.

## Operation
- Input stage: `iVGA_RGB`, `iHsync`, `iVsync` registered once (s1), then a second time (s2) for edge detection. Hsync rise = s1 high and s2 low; same for Vsync.
- x: set to 0 on an Hsync rise, else incremented; saturates at 1023.
- y: a Vsync rise sets `frame_pending`. On an Hsync rise:
  - if `frame_pending` (including a Vsync rise in the same cycle): y←0 and `frame_pending` cleared;
  - otherwise y←y+1, saturating at 1023.
- Period meter: counts cycles between Hsync rises, 11 bits, saturating at 2047.
  - On each Hsync rise the count is latched into `oLinePeriod` and compared with the previous value.
  - `oLocked` rises after `LOCK_LINES` consecutive equal periods.
  - `oLocked` clears on the first unequal period, or when the count reaches 2047 (no Hsync).
- FSM states:
  - IDLE: `oBusy`=0. `iCaptureRequest`=1 with `oLocked`=1 goes to ARM. A request while unlocked is ignored.
  - ARM: `oBusy`=1. On an Hsync rise that clears `frame_pending`, goes to CAPTURE; that line is y=0.
  - CAPTURE: `oBusy`=1. Every sample with x in [H_START, H_START+255] and y in [V_START, V_START+255] is written.
    - Address = {(y−V_START)[7:0], (x−H_START)[7:0]}; data = s1 colour.
    - After the write of address 0xFFFF, `oDone` pulses and the FSM returns to IDLE.
- `iCaptureRequest` while `oBusy`=1 is ignored.
- Lock loss in ARM or CAPTURE: `oError` pulse, return to IDLE, no `oDone`. Writes already issued are not retracted.
- Exactly 65536 writes per successful capture, each address exactly once, in ascending order.

## Timing
- Reset value of every output is 0. `Reset` low for one edge forces IDLE, clears x, y, `frame_pending`, the period meter and lock, from any state.
- Latency: a pixel on the inputs at edge t appears as a write at edge t+2.
- Hsync rise is detected at edge t+2 relative to the input transition.
- `oDone` is asserted in the cycle after the final write. `oBusy` falls in the same cycle as `oDone` or `oError` is asserted.
- Lock is earliest at the `LOCK_LINES`+1-th Hsync rise after reset.
- For the standard 800×521 stream, `oLinePeriod`=800.

## Structure
- Shared definitions file holds: FSM state encodings (IDLE/ARM/CAPTURE), window size 256, default H_START/V_START, period counter width 11 and saturation value 2047.
- One sub-module, `vga_line_period_meter`:
  - inputs: Hsync-rise strobe, clock, reset;
  - outputs: `oLinePeriod`, `oLocked`.
- Position recovery, window compare, address generation and FSM live in the top module.

## Test plan
- Reset, then 5 lines of 800 cycles each -> `oLocked`=1 at the 5th Hsync rise; `oLinePeriod`=800; all outputs 0 before lock.
- Locked stream with colour = (x^y)[2:0], request pulse -> 65536 writes.
  - First write: address 0x0000, data (240^141)[2:0].
  - Last write: address 0xFFFF.
  - `oDone` pulses once, one cycle after the last write.
- During CAPTURE, one line of 799 cycles -> `oLocked` falls, `oError` pulses once, `oDone` never asserted, write count < 65536.
- Request while unlocked -> no state change, `oBusy`=0. A second request during CAPTURE -> ignored; exactly 65536 writes.
- Vsync rise 3 cycles before an Hsync rise -> that line is y=0; first write still lands on line V_START after it.
- Reset pulsed low mid-CAPTURE -> next cycle all outputs 0, lock lost, no further writes.
